// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared address widths, TLB entry and FSM state types
package params_pkg;

  localparam int VADDR_WIDTH   = 32;
  localparam int PADDR_WIDTH   = 34;
  localparam int PAGE_OFFSET_W = 12;
  localparam int VPN_W         = 20;
  localparam int PPN_W         = PADDR_WIDTH - PAGE_OFFSET_W;

  typedef logic [VADDR_WIDTH-1:0] vaddr_t;
  typedef logic [PADDR_WIDTH-1:0] paddr_t;
  typedef logic [VPN_W-1:0]       vpn_t;
  typedef logic [PPN_W-1:0]       ppn_t;

  typedef struct packed {
    logic valid;
    vpn_t vpn;
    ppn_t ppn;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WALK   = 2'd2,
    ST_RESP   = 2'd3
  } tlb_state_e;

endpackage

// File: rtl/tlb_if.sv
// rtl/tlb_if.sv - request/response and page-table-walker signals of the TLB
interface tlb_if
  import params_pkg::*;
#(
  parameter int PADDR_WIDTH = params_pkg::PADDR_WIDTH
);
  logic                   req_valid_i;
  logic                   req_ready_o;
  vaddr_t                 req_vaddr_i;
  logic                   resp_valid_o;
  logic                   resp_ready_i;
  logic [PADDR_WIDTH-1:0] resp_paddr_o;
  logic                   resp_error_o;
  logic                   ptw_req_o;
  vaddr_t                 ptw_vaddr_o;
  logic                   ptw_valid_i;
  logic                   ptw_error_i;
  logic [PADDR_WIDTH-1:0] ptw_paddr_i;

  modport slave (
    input  req_valid_i, req_vaddr_i, resp_ready_i, ptw_valid_i, ptw_error_i, ptw_paddr_i,
    output req_ready_o, resp_valid_o, resp_paddr_o, resp_error_o, ptw_req_o, ptw_vaddr_o
  );

  modport master (
    output req_valid_i, req_vaddr_i, resp_ready_i, ptw_valid_i, ptw_error_i, ptw_paddr_i,
    input  req_ready_o, resp_valid_o, resp_paddr_o, resp_error_o, ptw_req_o, ptw_vaddr_o
  );
endinterface

// File: rtl/tlb_cam.sv
// rtl/tlb_cam.sv - tag compare and priority encode over all TLB entries
module tlb_cam
  import params_pkg::*;
#(
  parameter  int NUM_ENTRIES = 4,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] valid_i,
  input  vpn_t [NUM_ENTRIES-1:0] tags_i,
  input  vpn_t                   vpn_i,
  output logic                   hit_o,
  output logic [IDX_W-1:0]       hit_idx_o,
  output logic [IDX_W-1:0]       free_idx_o,
  output logic                   all_valid_o
);

  logic [NUM_ENTRIES-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = valid_i[i] && (tags_i[i] == vpn_i);
    end
  end

  // Descending scan so the lowest index wins; match is at most one-hot anyway.
  always_comb begin
    hit_idx_o  = '0;
    free_idx_o = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match[i])    hit_idx_o  = IDX_W'(i);
      if (!valid_i[i]) free_idx_o = IDX_W'(i);
    end
  end

  assign hit_o       = |match;
  assign all_valid_o = &valid_i;

endmodule

// File: rtl/tlb.sv
// rtl/tlb.sv - fully-associative TLB in front of the page-table walker (optional TLB_FLUSH_EN adds flush_i)
module tlb #(
  parameter int NUM_ENTRIES = 4,
  parameter int PADDR_WIDTH = params_pkg::PADDR_WIDTH
) (
  input  logic   clk_i,
  input  logic   rst_i,
`ifdef TLB_FLUSH_EN
  input  logic   flush_i,
`endif
  tlb_if.slave   bus
);
  import params_pkg::*;

  localparam int IDX_W  = $clog2(NUM_ENTRIES);
  localparam int PPNW_L = PADDR_WIDTH - PAGE_OFFSET_W;

  tlb_state_e                          state_q, state_d;
  vaddr_t                              vaddr_q;
  logic [PADDR_WIDTH-1:0]              resp_paddr_q, resp_paddr_d;
  logic                                resp_error_q, resp_error_d;
  logic [NUM_ENTRIES-1:0]              valid_q;
  vpn_t [NUM_ENTRIES-1:0]              tags_q;
  logic [NUM_ENTRIES-1:0][PPNW_L-1:0]  ppns_q;
  logic [IDX_W-1:0]                    rr_q;
  logic                                flushed_q;

  logic             load_req;
  logic             fill_en;
  logic             cam_hit;
  logic             cam_all_valid;
  logic [IDX_W-1:0] cam_hit_idx;
  logic [IDX_W-1:0] cam_free_idx;
  logic [IDX_W-1:0] fill_idx;
  logic             flush_w;
  logic             unused_paddr_lsbs;

`ifdef TLB_FLUSH_EN
  assign flush_w = flush_i;
`else
  assign flush_w = 1'b0;
`endif

  assign unused_paddr_lsbs = ^bus.ptw_paddr_i[PAGE_OFFSET_W-1:0];

  tlb_cam #(.NUM_ENTRIES(NUM_ENTRIES)) u_cam (
    .valid_i     (valid_q),
    .tags_i      (tags_q),
    .vpn_i       (vaddr_q[31:PAGE_OFFSET_W]),
    .hit_o       (cam_hit),
    .hit_idx_o   (cam_hit_idx),
    .free_idx_o  (cam_free_idx),
    .all_valid_o (cam_all_valid)
  );

  assign fill_idx = cam_all_valid ? rr_q : cam_free_idx;

  always_comb begin
    state_d      = state_q;
    load_req     = 1'b0;
    fill_en      = 1'b0;
    resp_paddr_d = resp_paddr_q;
    resp_error_d = resp_error_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          load_req = 1'b1;
          state_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (cam_hit && !flush_w) begin
          resp_paddr_d = {ppns_q[cam_hit_idx], vaddr_q[PAGE_OFFSET_W-1:0]};
          resp_error_d = 1'b0;
          state_d      = ST_RESP;
        end else begin
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        if (bus.ptw_error_i) begin
          resp_paddr_d = '0;
          resp_error_d = 1'b1;
          state_d      = ST_RESP;
        end else if (bus.ptw_valid_i) begin
          resp_paddr_d = {bus.ptw_paddr_i[PADDR_WIDTH-1:PAGE_OFFSET_W],
                          vaddr_q[PAGE_OFFSET_W-1:0]};
          resp_error_d = 1'b0;
          // A flush seen at any point of this walk makes the result stale for caching.
          fill_en      = !flush_w && !flushed_q;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      vaddr_q      <= '0;
      resp_paddr_q <= '0;
      resp_error_q <= 1'b0;
      flushed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_paddr_q <= resp_paddr_d;
      resp_error_q <= resp_error_d;
      if (load_req) vaddr_q <= bus.req_vaddr_i;
      if (state_q == ST_WALK) flushed_q <= flushed_q | flush_w;
      else                    flushed_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      tags_q  <= '0;
      ppns_q  <= '0;
      rr_q    <= '0;
    end else if (flush_w) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
      tags_q[fill_idx]  <= vaddr_q[31:PAGE_OFFSET_W];
      ppns_q[fill_idx]  <= bus.ptw_paddr_i[PADDR_WIDTH-1:PAGE_OFFSET_W];
      if (cam_all_valid) rr_q <= rr_q + 1'b1;
    end
  end

  assign bus.req_ready_o  = (state_q == ST_IDLE);
  assign bus.resp_valid_o = (state_q == ST_RESP);
  assign bus.ptw_req_o    = (state_q == ST_WALK);
  assign bus.ptw_vaddr_o  = vaddr_q;
  assign bus.resp_paddr_o = resp_paddr_q;
  assign bus.resp_error_o = resp_error_q;

endmodule

// File: tb/tb_tlb.sv
// tb/tb_tlb.sv - scoreboard bench for tlb: hits, walks, faults, replacement, reset abort, flush
module tb_tlb;
  localparam int PW = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef TLB_FLUSH_EN
  logic flush = 1'b0;
`endif

  always #5 clk = ~clk;

  tlb_if #(.PADDR_WIDTH(PW)) bus ();

  tlb #(.NUM_ENTRIES(4), .PADDR_WIDTH(PW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
`ifdef TLB_FLUSH_EN
    .flush_i (flush),
`endif
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Walker mapping: PPN = {2'b01, VPN}; walker's low 12 bits are junk on purpose.
  function automatic logic [PW-1:0] walk_pa(input logic [31:0] va);
    return {2'b01, va[31:12], 12'hFFF};
  endfunction

  function automatic logic [PW-1:0] model_pa(input logic [31:0] va);
    return {2'b01, va[31:12], va[11:0]};
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"},  64'(bus.req_ready_o),  64'd1);
    check({pfx, "_resp_valid"}, 64'(bus.resp_valid_o), 64'd0);
    check({pfx, "_resp_error"}, 64'(bus.resp_error_o), 64'd0);
    check({pfx, "_resp_paddr"}, 64'(bus.resp_paddr_o), 64'd0);
    check({pfx, "_ptw_req"},    64'(bus.ptw_req_o),    64'd0);
    check({pfx, "_ptw_vaddr"},  64'(bus.ptw_vaddr_o),  64'd0);
  endtask

  task automatic xact(input logic [31:0] va, input int d, input bit werr,
                      input bit exp_hit, input int hold);
    int cyc;
    int walks;
    logic [63:0] e;
    logic [PW-1:0] held_pa;
    @(negedge clk);
    check("req_ready_idle", 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_vaddr_i = va;
    exp_q.push_back({29'd0, werr, (werr ? {PW{1'b0}} : model_pa(va))});
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    cyc   = 1;
    walks = 0;
    while (!bus.resp_valid_o && cyc < 60) begin
      if (bus.ptw_req_o) begin
        if (walks == 0) check("ptw_vaddr", 64'(bus.ptw_vaddr_o), 64'(va));
        walks++;
        if (walks > d) begin
          bus.ptw_valid_i = !werr;
          bus.ptw_error_i = werr;
          bus.ptw_paddr_i = walk_pa(va);
        end
      end
      @(negedge clk);
      bus.ptw_valid_i = 1'b0;
      bus.ptw_error_i = 1'b0;
      bus.ptw_paddr_i = '0;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(exp_hit ? 2 : 3 + d));
    check("walk_cycles", 64'(walks), 64'(exp_hit ? 0 : d + 1));
    e = exp_q.pop_front();
    check("resp_valid", 64'(bus.resp_valid_o), 64'd1);
    check("resp_paddr", 64'(bus.resp_paddr_o), 64'(e[PW-1:0]));
    check("resp_error", 64'(bus.resp_error_o), 64'(e[PW]));
    held_pa = bus.resp_paddr_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.resp_valid_o), 64'd1);
      check("hold_paddr", 64'(bus.resp_paddr_o), 64'(held_pa));
      check("hold_req_ready", 64'(bus.req_ready_o), 64'd0);
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    check("back_idle", 64'(bus.req_ready_o), 64'd1);
    check("resp_dropped", 64'(bus.resp_valid_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_vaddr_i  = '0;
    bus.resp_ready_i = 1'b0;
    bus.ptw_valid_i  = 1'b0;
    bus.ptw_error_i  = 1'b0;
    bus.ptw_paddr_i  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    xact(32'h0000_5123, 0, 1'b0, 1'b0, 0);
    xact(32'h0000_5ABC, 0, 1'b0, 1'b1, 4);
    xact(32'h9000_0456, 2, 1'b1, 1'b0, 0);
    xact(32'h9000_0456, 1, 1'b0, 1'b0, 0);

    // Abort a walk with reset; entries must be gone afterwards.
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_vaddr_i = 32'h0007_7000;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("walk_before_rst", 64'(bus.ptw_req_o), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    xact(32'h0000_5123, 0, 1'b0, 1'b0, 0);

    // Fill remaining slots, then replacement walks the round-robin pointer.
    xact(32'h0001_1000, 0, 1'b0, 1'b0, 0);
    xact(32'h0001_2000, 0, 1'b0, 1'b0, 0);
    xact(32'h0001_3000, 3, 1'b0, 1'b0, 0);
    xact(32'h0001_4000, 0, 1'b0, 1'b0, 0);
    xact(32'h0001_1ABC, 0, 1'b0, 1'b1, 0);
    xact(32'h0001_4004, 0, 1'b0, 1'b1, 0);
    xact(32'h0000_5123, 0, 1'b1, 1'b0, 0);
    xact(32'h0000_5123, 0, 1'b0, 1'b0, 0);
    xact(32'h0001_1000, 0, 1'b0, 1'b0, 0);
    xact(32'h0001_3FFF, 0, 1'b0, 1'b1, 0);
    xact(32'h0001_2000, 0, 1'b0, 1'b0, 0);
    xact(32'h0000_5001, 0, 1'b0, 1'b1, 0);

`ifdef TLB_FLUSH_EN
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    xact(32'h0000_5123, 0, 1'b0, 1'b0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tlb.md
# tlb

Small fully-associative translation cache placed directly upstream of the page-table walker. Accepts virtual-address translation requests from the core/LSU, answers hits from its own entries, and on a miss drives the walker, fills an entry with the returned mapping, and returns the physical address or a page-fault error. Converts the walker's single-shot combinational translation into a registered, handshaked translation service.

## Interface
- `NUM_ENTRIES`, 4: number of TLB entries; power of two, ≥2.
- `PADDR_WIDTH`, `params_pkg::PADDR_WIDTH`: physical address width; >12.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: translation request valid.
- `req_ready_o` out 1: block can accept a request (high only in IDLE).
- `req_vaddr_i` in `vaddr_t`: virtual address to translate.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: consumer accepts response.
- `resp_paddr_o` out `paddr_t`: translated physical address.
- `resp_error_o` out 1: page fault; `resp_paddr_o` is zero when set.
- `ptw_req_o` out 1: walk request to the page-table walker.
- `ptw_vaddr_o` out `vaddr_t`: address to walk (registered request address).
- `ptw_valid_i` in 1: walker returned a valid mapping.
- `ptw_error_i` in 1: walker reports page not present.
- `ptw_paddr_i` in `paddr_t`: walker physical address.

## Operation
- 4 KiB pages: VPN = `vaddr[31:12]`, offset = `vaddr[11:0]`; PPN = `paddr[PADDR_WIDTH-1:12]`. Hit paddr = {entry PPN, registered offset}.
- Entry: valid bit, 20-bit VPN tag, PPN. Fills only occur on a miss, so at most one entry matches.
- FSM states: IDLE, LOOKUP, WALK, RESP.
  - IDLE: `req_ready_o`=1; on `req_valid_i` register vaddr and go to LOOKUP.
  - LOOKUP: compare VPN against all valid entries. Hit → load response regs, go to RESP. Miss → WALK.
  - WALK: `ptw_req_o`=1. Stays in WALK while neither `ptw_valid_i` nor `ptw_error_i` is set. `ptw_error_i` (priority over valid) → response error=1, paddr=0, no fill. `ptw_valid_i` → fill entry, response paddr = {`ptw_paddr_i` PPN, offset}, error=0. Both exits go to RESP.
  - RESP: `resp_valid_o`=1. Outputs are held stable until `resp_ready_i`, then go to IDLE.
- Replacement: fill the lowest-index invalid entry. If every entry is valid, fill the entry at the round-robin pointer and advance the pointer, wrapping from `NUM_ENTRIES-1` to 0. The pointer does not move on fills into invalid entries.
- Reset: all entries invalid, pointer 0, state IDLE. Reset asserted mid-walk or mid-response aborts the transaction and produces no fill.
- Reset values: `req_ready_o`=1 (IDLE), `resp_valid_o`=0, `resp_error_o`=0, `resp_paddr_o`=0, `ptw_req_o`=0, `ptw_vaddr_o`=0.

## Timing
- Request handshake completes on the rising edge where `req_valid_i` and `req_ready_o` are both high (cycle N).
- Hit: LOOKUP in N+1, `resp_valid_o` in N+2.
- Miss with a same-cycle walker response: WALK in N+2, `resp_valid_o` in N+3. Each extra walker cycle adds one cycle.
- Entry fill takes effect at the WALK exit edge, so a back-to-back request for the same page hits.
- Minimum back-to-back throughput: one translation per 3 cycles when `resp_ready_i` is held high.

## Configuration
- `TLB_FLUSH_EN` defined: adds input `flush_i` (1 bit).
  - `flush_i` in IDLE or LOOKUP clears all valid bits and resets the pointer to 0 on the next edge. A flush in LOOKUP forces a miss.
  - `flush_i` in WALK or RESP clears the entries, but the in-flight walk result is still returned and not filled.
- Undefined: no `flush_i` port; entries are cleared only by reset.

## Structure
- `params_pkg` additions: `PAGE_OFFSET_W`=12, `VPN_W`=20, typedef `vpn_t`, typedef `tlb_entry_t` (valid, vpn, ppn), enum `tlb_state_e`.
- Sub-module `tlb_cam`: combinational tag compare plus one-hot-to-index encode. Outputs hit, hit index, first-invalid index, and all-valid flag.

## Test plan
- Reset, then request 0x0000_5123; walker returns paddr 0x07123 → response at N+3 with paddr 0x07123, error=0, `ptw_req_o` high exactly one cycle.
- Repeat request 0x0000_5ABC → hit at N+2, paddr 0x07ABC, `ptw_req_o` stays 0.
- Miss with `ptw_error_i`=1 → `resp_error_o`=1, paddr 0; the same request again walks again (no fill).
- Fill 5 distinct pages with `NUM_ENTRIES`=4 → 5th page replaces entry 0; the 1st page then misses and the 2nd page hits.
- Hold `resp_ready_i`=0 for 4 cycles → response outputs stable and `req_ready_o`=0 throughout; release → IDLE next cycle.
- With `TLB_FLUSH_EN`: fill page 0x5, assert `flush_i` in IDLE, request page 0x5 → miss and walk. Separately, assert reset during WALK → all outputs at reset values and the next request misses.
